// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition encodings, PC FSM states, default vectors.
// No logic; constants and types only.
// Imported by pc_gen, branch_cmp and later pipeline hazard logic.
package cpu_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd2;
    localparam logic [2:0] BR_BGE  = 3'd3;
    localparam logic [2:0] BR_BLTU = 3'd4;
    localparam logic [2:0] BR_BGEU = 3'd5;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_TRAP_ENTRY,
        PC_HALT
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_1000;

endpackage

// File: rtl/branch_cmp.sv
// Branch predicate: decides whether a conditional branch is taken from the ALU flags.
// Latency: purely combinational.
// No backpressure; encodings 6-7 are never taken.
module branch_cmp
    import cpu_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    // Map the condition code onto the matching ALU flag or its complement.
    always_comb begin
        taken = 1'b0;
        case (br_cond)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = ~lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: picks the next fetch address among sequential, branch, jump, jr, trap and eret.
// Latency: one cycle from request to new pc; redirect/misalign pulse in the cycle after the load.
// stall freezes pc, epc and FSM and masks all requests. PC_PERF_CNT_EN adds instr/taken counters.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_ADDR  = XLEN'(DEF_RESET_ADDR),
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            branch,
    input  logic [2:0]      br_cond,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] addr_result,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            jr,
    input  logic [XLEN-1:0] jr_target,
    input  logic            trap,
    input  logic            trap_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] branch_base_addr,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] epc,
    output logic            redirect,
    output logic            misalign,
    output logic            halted
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]     instr_cnt,
    output logic [31:0]     taken_cnt
`endif
);

    // Low address bits that must be zero for a legal instruction target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    pc_state_t       state;
    logic            cond_true;
    logic            br_taken;
    logic            sel_vld;
    logic [XLEN-1:0] sel_tgt;
    logic            tgt_misaligned;

    branch_cmp u_branch_cmp (
        .br_cond (br_cond),
        .zero    (zero),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (cond_true)
    );

    assign br_taken         = branch & cond_true;
    assign pc_plus          = pc + XLEN'(INSTR_BYTES);
    assign branch_base_addr = pc;
    assign halted           = (state == PC_HALT);
    assign tgt_misaligned   = |(sel_tgt & ALIGN_MASK);

    // Priority select among non-trap redirect sources; trap is handled separately in the FSM.
    always_comb begin
        sel_vld = 1'b0;
        sel_tgt = '0;
        if (trap_ret) begin
            sel_vld = 1'b1;
            sel_tgt = epc;
        end else if (jr) begin
            sel_vld = 1'b1;
            sel_tgt = jr_target;
        end else if (jump) begin
            sel_vld = 1'b1;
            sel_tgt = jump_target;
        end else if (br_taken) begin
            sel_vld = 1'b1;
            sel_tgt = addr_result;
        end
    end

    // PC/EPC register and RUN/TRAP_ENTRY/HALT sequencing; pulses default low every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_ADDR;
            epc      <= '0;
            redirect <= 1'b0;
            misalign <= 1'b0;
            state    <= PC_RUN;
        end else begin
            redirect <= 1'b0;
            misalign <= 1'b0;
            if (!stall) begin
                case (state)
                    PC_RUN: begin
                        if (trap) begin
                            // Trap beats everything, including a same-cycle eret or halt.
                            pc       <= TRAP_VEC;
                            epc      <= pc;
                            redirect <= 1'b1;
                            state    <= PC_TRAP_ENTRY;
                        end else if (sel_vld && tgt_misaligned) begin
                            // A bad target turns the redirect into a trap on the current pc.
                            pc       <= TRAP_VEC;
                            epc      <= pc;
                            redirect <= 1'b1;
                            misalign <= 1'b1;
                            state    <= PC_TRAP_ENTRY;
                        end else if (sel_vld) begin
                            pc       <= sel_tgt;
                            redirect <= 1'b1;
                        end else if (halt) begin
                            state <= PC_HALT;
                        end else begin
                            pc <= pc_plus;
                        end
                    end
                    PC_TRAP_ENTRY: begin
                        // Single bubble at the handler entry; requests are dropped.
                        state <= PC_RUN;
                    end
                    PC_HALT: begin
                        if (resume) begin
                            pc    <= pc_plus;
                            state <= PC_RUN;
                        end
                    end
                    default: state <= PC_RUN;
                endcase
            end
        end
    end

`ifdef PC_PERF_CNT_EN
    // Retired-slot and taken-redirect counters; both wrap naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else if (!stall && state == PC_RUN) begin
            instr_cnt <= instr_cnt + 32'd1;
            if (!trap && sel_vld && !tgt_misaligned) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter unit; successor to the single-cycle PC register. Selects next PC from sequential, conditional-branch, jump, register-jump, trap-vector and trap-return sources. Supports stall, halt/resume, and misaligned-target trapping with EPC capture. Sits between the controller/ALU and instruction memory; `pc` drives the fetch address.

Parameters:
XLEN, 32, address/data width
RESET_ADDR, 32'h0000_0000, PC value after reset
TRAP_VEC, 32'h0000_1000, trap handler entry address
INSTR_BYTES, 4, sequential increment; must be power of 2

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and state; all redirect requests ignored
halt  in  1  enter HALT from RUN
resume  in  1  leave HALT
branch  in  1  conditional branch instruction in execute
br_cond  in  3  0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu; 6–7 never taken
zero  in  1  ALU equal flag
lt  in  1  ALU signed less-than flag
ltu  in  1  ALU unsigned less-than flag
addr_result  in  XLEN  branch target from ALU
jump  in  1  unconditional jump (j/jal)
jump_target  in  XLEN  jump target
jr  in  1  register jump
jr_target  in  XLEN  register value
trap  in  1  external or illegal-instruction trap request
trap_ret  in  1  return from trap (eret)
pc  out  XLEN  current fetch address
branch_base_addr  out  XLEN  equals pc
pc_plus  out  XLEN  pc + INSTR_BYTES, also the link address
epc  out  XLEN  PC of trapping instruction
redirect  out  1  one-cycle pulse: next PC is not pc_plus
misalign  out  1  one-cycle pulse: selected target misaligned; trap taken
halted  out  1  FSM in HALT

Behaviour:
- Reset is asynchronous, active-high, on clock. Reset values: pc=RESET_ADDR, epc=0, redirect=0, misalign=0, halted=0, state RUN.
- Branch taken when branch=1 and the br_cond predicate holds:
  - beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu.
- Next-PC priority, evaluated only in RUN with stall=0:
  1. trap: target TRAP_VEC, epc<=pc.
  2. trap_ret: target epc.
  3. jr: target jr_target.
  4. jump: target jump_target.
  5. branch taken: target addr_result.
  6. otherwise pc_plus.
- Misalignment: if the selected target from source 2–5 has low log2(INSTR_BYTES) bits nonzero:
  - pc<=TRAP_VEC, epc<=pc, misalign=1.
  - This counts as a trap.
- redirect is registered: 1 in the cycle after any non-sequential PC load, otherwise 0.
- FSM states:
  - RUN → TRAP_ENTRY on trap or misalign. pc is already loaded with TRAP_VEC.
  - TRAP_ENTRY: a one-cycle bubble that holds pc; all requests are ignored except reset. Then → RUN.
  - RUN → HALT on halt=1 with stall=0. pc holds. If trap is asserted in the same cycle, trap wins and halt is ignored.
  - HALT → RUN on resume=1. pc<=pc_plus. halted stays 1 while in HALT.
- stall=1 freezes pc, epc, and the FSM. redirect and misalign drive 0 while stalled.
- Width rules:
  - pc_plus wraps modulo 2^XLEN, so XLEN'hFFFF_FFFC+4 = 0.
  - No overflow flag.
- trap and trap_ret in the same cycle: trap wins, and epc takes the current pc.
- Reset mid-TRAP_ENTRY or mid-HALT: returns to RUN with pc=RESET_ADDR.

Optional Feature:
PC_PERF_CNT_EN.
- Defined: adds outputs instr_cnt[31:0] and taken_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - instr_cnt increments on each RUN cycle with stall=0.
  - taken_cnt increments on each cycle where a redirect is taken (branch/jump/jr/trap_ret).
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - br_cond encodings BR_BEQ..BR_BGEU;
  - FSM state typedef pc_state_t {PC_RUN, PC_TRAP_ENTRY, PC_HALT};
  - default TRAP_VEC and RESET_ADDR constants.
- One natural sub-module: branch_cmp, a combinational predicate from br_cond/zero/lt/ltu to taken, reused by later pipeline hazard logic.

Test Plan:
- Reset, then 3 cycles with no requests → pc 0,4,8,12; redirect=0.
- branch=1, br_cond=1 (bne), zero=0, addr_result=0x40 at pc=8 → next pc=0x40, redirect=1 the following cycle. Same with zero=1 → pc=0xC.
- trap=1 at pc=0x20 → pc=0x1000, epc=0x20, one cycle held in TRAP_ENTRY. Then trap_ret=1 → pc=0x20.
- jr=1, jr_target=0x102 → pc=0x1000, misalign=1, epc=old pc.
- stall=1 for 4 cycles with jump=1 → pc unchanged, redirect=0. halt → halted=1 and pc frozen; resume → pc+4.
- pc=0xFFFF_FFFC with no requests → pc=0x0. With PC_PERF_CNT_EN defined, 10 RUN cycles including 2 jumps → instr_cnt=10, taken_cnt=2.
